// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: mode encodings, LFSR tap table and seed helper for shift_seq_counter
package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // Masks m give x^W + sum(m_i x^i) primitive, so fb = ^(q & m) fed into the MSB
    // of a right shift yields a maximal-length sequence for widths 3..8.
    function automatic logic [7:0] lfsr_taps(input int width);
        return width == 5 ? 8'h05 : width == 8 ? 8'h1D : 8'h03;
    endfunction

    function automatic logic [7:0] seed(input mode_e mode, input int width);
        return mode == MODE_JOHNSON ? 8'h00 : 8'h01 << (width - 1);
    endfunction

endpackage

// File: rtl/shift_seq_legal.sv
// shift_seq_legal: combinational legality check and seed value for the selected mode
//   q     in  WIDTH  current counter state
//   mode  in  2      mode whose rules apply
//   legal out 1      q is a member of that mode's sequence (always 1 in hold)
//   seed  out WIDTH  restart value for that mode
module shift_seq_legal
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    output logic             legal,
    output logic [WIDTH-1:0] seed
);

    localparam logic [7:0] SEED_ONE = shift_seq_pkg::seed(MODE_RING, WIDTH);
    localparam logic [7:0] SEED_JOH = shift_seq_pkg::seed(MODE_JOHNSON, WIDTH);

    assign seed = mode == MODE_JOHNSON ? SEED_JOH[WIDTH-1:0] : SEED_ONE[WIDTH-1:0];

    // A Johnson state has at most one boundary between its run of ones and zeros.
    assign legal = mode == MODE_RING    ? $countones(q) == 1 :
                   mode == MODE_JOHNSON ? $countones(q[WIDTH-2:0] ^ q[WIDTH-1:1]) <= 1 :
                   mode == MODE_LFSR    ? |q : 1'b1;

endmodule

// File: rtl/shift_seq_counter.sv
// shift_seq_counter: run-time selectable ring / Johnson / LFSR shift-sequence counter
//   clk   in  1      rising-edge clock
//   clr   in  1      asynchronous active-high reset
//   en    in  1      advance one step per clock
//   mode  in  2      00 ring, 01 Johnson, 10 LFSR, 11 hold
//   dir   in  1      0 shift right, 1 shift left (ignored for LFSR)
//   ld    in  1      synchronous parallel load of din
//   din   in  WIDTH  load value
//   q     out WIDTH  counter state
//   wrap  out 1      pulse: last normal step returned q to the seed
//   err   out 1      sticky: an illegal state was corrected
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    localparam logic [7:0] TAPS  = lfsr_taps(WIDTH);
    localparam logic [7:0] RST_Q = shift_seq_pkg::seed(MODE_RING, WIDTH);

    mode_e            mode_i, mode_q;
    logic             legal, reseed, adv, norm, fb;
    logic [WIDTH-1:0] seed, step, q_n;

    assign mode_i = mode_e'(mode);

    shift_seq_legal #(.WIDTH(WIDTH)) u_legal (
        .q     (q),
        .mode  (mode_i),
        .legal (legal),
        .seed  (seed)
    );

    // A step only happens when mode_i == mode_q, so the legality/seed of mode_i
    // serve both the reseed and the step-correction paths.
    assign reseed = mode_i != MODE_HOLD && mode_i != mode_q;
    assign adv    = en && mode_i != MODE_HOLD;
    assign norm   = adv && !ld && !reseed;
    assign fb     = ^(q & TAPS[WIDTH-1:0]);

    assign step = mode_q == MODE_LFSR    ? {fb, q[WIDTH-1:1]} :
                  mode_q == MODE_JOHNSON ? (dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]}) :
                  dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};

    assign q_n = ld ? din : reseed ? seed : !norm ? q : legal ? step : seed;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q      <= RST_Q[WIDTH-1:0];
            mode_q <= MODE_RING;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            q      <= q_n;
            mode_q <= reseed ? mode_i : mode_q;
            wrap   <= norm && legal && step == seed;
            err    <= err | (norm && !legal);
        end
    end

endmodule

// File: doc/shift_seq_counter.md
# shift_seq_counter

Parametrised shift-sequence counter, the next generation of the lab's 4-bit ring/Johnson counter. It provides a WIDTH-bit ring, Johnson (twisted-ring) or maximal-length LFSR sequence, selected at run time. Beyond the earlier block it adds enable, synchronous parallel load, shift direction, automatic recovery from illegal states, a sticky error flag and a wrap pulse. It sits in the S4 lab sequencer library as the common source of one-hot phases, 2·WIDTH-phase clocks and pseudo-random patterns.

## Interface
- WIDTH, 4, counter width; legal range 3..8 (LFSR tap table limit)
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- en  in  1  advance one step per clock when high
- mode  in  2  00 ring, 01 Johnson, 10 LFSR, 11 hold
- dir  in  1  0 shift right (toward bit 0), 1 shift left; ignored in LFSR mode
- ld  in  1  synchronous parallel load
- din  in  WIDTH  load value
- q  out  WIDTH  counter state
- wrap  out  1  one-cycle pulse: the last step returned q to the mode seed
- err  out  1  sticky: an illegal state was detected and corrected

## Operation
- Seeds: ring 1000…0 (MSB set); Johnson all-zero; LFSR 1000…0.
- Steps, dir=0: ring q <= {q[0], q[W-1:1]}; Johnson q <= {~q[0], q[W-1:1]}.
- Steps, dir=1: ring q <= {q[W-2:0], q[W-1]}; Johnson q <= {q[W-2:0], ~q[W-1]}.
- LFSR step: q <= {fb, q[W-1:1]}, where fb = XOR of q bits selected by the package tap mask. WIDTH=4 uses mask 0011, i.e. fb = q[0]^q[1].
- Periods: ring WIDTH, Johnson 2·WIDTH, LFSR 2^WIDTH−1.
- Legality checks:
  - ring: exactly one bit set.
  - Johnson: at most one i in 0..W−2 with q[i]≠q[i+1].
  - LFSR: q ≠ 0.
- Mode tracking: register mode_q holds the last non-hold mode. When mode ∉ {11} and mode ≠ mode_q, q <= new seed and mode_q <= mode in that cycle; this happens regardless of en.
- Hold mode (11): q frozen, mode_q unchanged. Returning to the same mode resumes without a reseed.
- Priority per clock: clr > ld > mode-change reseed > (en and hold-not-selected) step > hold.
- ld accepts din as-is, even if illegal.
- Illegal state on an enabled step: q <= seed instead of the step result, and err <= 1.
- err clears only on clr.
- wrap <= 1 iff a normal enabled step produced q == seed. Reseed, load and correction never pulse wrap.

## Timing
- Reset (async assert, no clock needed): q = 1000…0, mode_q = 00, wrap = 0, err = 0.
- Reset release is sampled synchronously. If mode ≠ 00 at the first edge after release, a reseed occurs on that edge.
- All outputs are registered.
- q changes one cycle after en/ld/mode is sampled.
- wrap is coincident with the q == seed value it flags.
- clr asserted mid-sequence forces the reset values immediately; the sequence restarts from the ring seed.
- ld and en high together: the load wins and no step occurs.
- ld during a mode change: the load wins, but mode_q still updates.
- en=0: q and err are held; wrap is 0.

## Structure
- Package shift_seq_pkg:
  - mode encodings MODE_RING/JOHNSON/LFSR/HOLD.
  - function lfsr_taps(width) returning the maximal-length tap mask for 3..8 (4 → 0011).
  - function seed(mode, width).
- Sub-module shift_seq_legal (combinational): inputs q and mode; outputs legal and seed. It keeps the legality and seed logic separate from the sequencing register.
- Top: mode_q register, next-state mux, err/wrap registers.

## Test plan
- Reset, then ring, dir=0, en=1 for 8 clocks → q: 1000, 0100, 0010, 0001, 1000, …; wrap high on each return to 1000; err=0.
- Johnson, dir=0, from the reseed → 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap on 0000 after 8 steps. Repeat with dir=1 → 0000, 0001, 0011, 0111, 1111, 1110, …
- LFSR from 1000 → 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, 1000; wrap after exactly 15 steps.
- Ring mode, ld=1 din=0110, then en → q=0110, then 1000 with err=1. Load 0000 in LFSR → next step 1000, err stays 1 until clr.
- Mid-sequence switch ring→hold→ring: q frozen during hold, no reseed on return. Switch ring→Johnson: q=0000 next clock, even with en=0.
- clr pulse asserted between clock edges while the counter runs → q=1000, err=0 immediately. ld and en together with din=0101 → q=0101, no step.
